ysyx_25030093_wbu: RTL

Writeback unit of the NPC core: the producer side of the register-file write port (`wdata`/`waddr`/`wen`). It accepts one retiring instruction at a time from the execute stage and, for loads, waits for the memory read response and sign/zero-extends it. It then drives a single-cycle register-file write strobe together with a commit pulse carrying the instruction PC. Sits between EXU/LSU and the register file; back-to-back ALU instructions retire at one per cycle.

---
 rtl/ysyx_25030093_pkg.sv | 16 +
 rtl/ysyx_25030093_loadext.sv | 38 +++
 rtl/ysyx_25030093_wbu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_pkg.sv
// Shared types for the NPC writeback unit: FSM states and load funct3 codes.
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_25030093_loadext.sv
// Load data extraction: picks the addressed byte/halfword of an aligned word
// and sign- or zero-extends it according to the load funct3.
module ysyx_25030093_loadext
  import ysyx_25030093_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword loads ignore off[0]; misaligned halfwords are not split.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    ext = rdata;
    case (ld_type)
      LB:      ext = {{24{byte_sel[7]}}, byte_sel};
      LH:      ext = {{16{half_sel[15]}}, half_sel};
      LW:      ext = rdata;
      LBU:     ext = {24'd0, byte_sel};
      LHU:     ext = {16'd0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: retires one instruction at a time, waits for load data,
// and drives a one-cycle register-file write plus commit pulse.
module ysyx_25030093_wbu
  import ysyx_25030093_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_ld_type,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_rready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [31:0]           commit_pc
);

  wbu_state_e state, state_next;

  logic                  accept;
  logic                  load_done;
  logic [31:0]           ext_word;

  logic [31:0]           pend_pc;
  logic [ADDR_WIDTH-1:0] pend_rd;
  logic                  pend_wen;
  logic [2:0]            pend_ld_type;
  logic [1:0]            pend_off;

  logic [31:0]           out_pc;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_wen;
  logic [DATA_WIDTH-1:0] out_data;

  assign accept    = in_valid & in_ready;
  assign load_done = (state == WAIT_MEM) & mem_rvalid;

  ysyx_25030093_loadext u_loadext (
    .rdata   (mem_rdata),
    .off     (pend_off),
    .ld_type (pend_ld_type),
    .ext     (ext_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    mem_rready   = 1'b0;
    rf_wen       = 1'b0;
    commit_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_next = WRITE;
      end
      WRITE: begin
        in_ready     = 1'b1;
        rf_wen       = out_wen & (out_rd != '0);
        commit_valid = 1'b1;
        if (in_valid) state_next = in_is_load ? WAIT_MEM : WRITE;
        else          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending regs hold a load while it waits; output regs change only on
  // entry to WRITE so the data outputs keep their last values elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc      <= '0;
      pend_rd      <= '0;
      pend_wen     <= 1'b0;
      pend_ld_type <= '0;
      pend_off     <= '0;
      out_pc       <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
      out_data     <= '0;
    end else if (accept) begin
      pend_pc      <= in_pc;
      pend_rd      <= in_rd;
      pend_wen     <= in_rd_wen;
      pend_ld_type <= in_ld_type;
      pend_off     <= in_alu_res[1:0];
      if (!in_is_load) begin
        out_pc   <= in_pc;
        out_rd   <= in_rd;
        out_wen  <= in_rd_wen;
        out_data <= in_alu_res;
      end
    end else if (load_done) begin
      out_pc   <= pend_pc;
      out_rd   <= pend_rd;
      out_wen  <= pend_wen;
      out_data <= ext_word;
    end
  end

  assign rf_waddr  = out_rd;
  assign rf_wdata  = out_data;
  assign commit_pc = out_pc;

endmodule
